// File: rtl/store_diffusion_errors.sv
// Splits the six chroma DC diffusion errors of a macroblock into left errors and top errors and
// owns the top-error line buffer. Optional macro STORE_DERR_CLEAR_EN adds a frame-start clear sweep.
module store_diffusion_errors #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              start,
  input  logic [ADDR_W-1:0] x,
  input  logic [47:0]       derr,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data,
  output logic [31:0]       left_derr,
  output logic              done,
  output logic              busy
);

  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] x_r;
  logic [47:0]       derr_r;
  logic [31:0]       left_r;
  logic [31:0]       top_r;
  logic [31:0]       mem [DEPTH];
  logic              wr_en_s;
  logic              clearing_s;

  // Second left error: floor(3*e3/4) evaluated in 10-bit signed arithmetic.
  function automatic logic [7:0] left1(input logic [7:0] e3);
    logic signed [9:0] p;
    p = $signed({{2{e3[7]}}, e3}) * 10'sd3;
    p = p >>> 2;
    return p[7:0];
  endfunction

  // A frame start in the WRITE cycle aborts the store, so it also blocks the RAM write.
  assign wr_en_s = (state_r == WRITE) && !frame_start && ({1'b0, x_r} < DEPTH_C);

`ifdef STORE_DERR_CLEAR_EN
  localparam int              LAST   = DEPTH - 1;
  localparam logic [ADDR_W:0] LAST_C = LAST[ADDR_W:0];
  localparam logic [ADDR_W:0] ONE_C  = {{ADDR_W{1'b0}}, 1'b1};

  logic            busy_r;
  logic [ADDR_W:0] clr_cnt_r;

  // Clear sweep: one word per cycle for DEPTH cycles; a new frame start restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r    <= 1'b0;
      clr_cnt_r <= '0;
    end else if (frame_start) begin
      busy_r    <= 1'b1;
      clr_cnt_r <= '0;
    end else if (busy_r) begin
      if (clr_cnt_r == LAST_C) begin
        busy_r <= 1'b0;
      end else begin
        busy_r <= 1'b1;
      end
      clr_cnt_r <= clr_cnt_r + ONE_C;
    end else begin
      busy_r    <= 1'b0;
      clr_cnt_r <= clr_cnt_r;
    end
  end

  assign clearing_s = busy_r;
  assign busy       = busy_r;
`else
  assign clearing_s = 1'b0;
  assign busy       = 1'b0;
`endif

  // Line-buffer write port (contents are not reset).
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[x_r] <= top_r;
`ifdef STORE_DERR_CLEAR_EN
    end else if (busy_r) begin
      mem[clr_cnt_r[ADDR_W-1:0]] <= 32'h0000_0000;
`endif
    end
  end

  // Read port with write-first bypass; holds its value between strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= 32'h0000_0000;
    end else if (rd_en) begin
      if (clearing_s) begin
        rd_data <= 32'h0000_0000;
      end else if (wr_en_s && (rd_addr == x_r)) begin
        rd_data <= top_r;
      end else if ({1'b0, rd_addr} < DEPTH_C) begin
        rd_data <= mem[rd_addr];
      end else begin
        rd_data <= 32'h0000_0000;
      end
    end
  end

  // Store sequencer; frame start overrides every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      x_r       <= '0;
      derr_r    <= 48'h0;
      left_r    <= 32'h0000_0000;
      top_r     <= 32'h0000_0000;
      left_derr <= 32'h0000_0000;
      done      <= 1'b0;
    end else if (frame_start) begin
      state_r   <= IDLE;
      left_derr <= 32'h0000_0000;
      done      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start && !clearing_s) begin
            x_r     <= x;
            derr_r  <= derr;
            state_r <= CALC;
          end
        end
        CALC: begin
          left_r  <= {left1(derr_r[47:40]), derr_r[31:24],
                      left1(derr_r[23:16]), derr_r[7:0]};
          top_r   <= {derr_r[47:40] - left1(derr_r[47:40]), derr_r[39:32],
                      derr_r[23:16] - left1(derr_r[23:16]), derr_r[15:8]};
          state_r <= WRITE;
        end
        WRITE: begin
          left_derr <= left_r;
          done      <= 1'b1;
          state_r   <= DONE;
        end
        DONE: begin
          done    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
